// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus controller and its lane aligner.
package mem_bus_pkg;

  localparam int unsigned REGION_SHIFT = 28;
  localparam int unsigned MAX_REGIONS  = 16;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  // True when an access of the given size is not naturally aligned at byte offset off.
  function automatic logic misaligned(logic [1:0] size, logic [1:0] off);
    case (size)
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: write strobes/replicated write data from the request,
// and right-aligned, size-masked read data from the selected slave word.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [1:0]  wr_size_i,
  input  logic [1:0]  wr_off_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  rd_size_i,
  input  logic [1:0]  rd_off_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rd_shifted;

  always_comb begin
    wstrb_o = 4'h0;
    wdata_o = wdata_i;
    case (wr_size_i)
      SZ_BYTE: begin
        wstrb_o = 4'b0001 << wr_off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        // Lanes shifted past byte 3 fall off the 4-bit strobe.
        wstrb_o = 4'b0011 << wr_off_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      SZ_WORD: wstrb_o = 4'hF;
      default: ;
    endcase
    if (!we_i) wstrb_o = 4'h0;
  end

  assign rd_shifted = rdata_i >> {rd_off_i, 3'b000};

  always_comb begin
    rdata_o = rd_shifted;
    case (rd_size_i)
      SZ_BYTE: rdata_o = {24'h0, rd_shifted[7:0]};
      SZ_HALF: rdata_o = {16'h0, rd_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU-to-memory valid/ready bus controller with region decode and access checks.
// Define BUS_TIMEOUT_EN to abort ACCESS with a bus error after TIMEOUT_CYCLES without ack.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned NUM_REGIONS    = 3,
  parameter logic [15:0] READ_ONLY_MASK = 16'h0001,
  parameter logic [15:0] ALIGN_MASK     = 16'h0004,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [31:0]               req_addr_i,
  input  logic                      req_we_i,
  input  logic [1:0]                req_size_i,
  input  logic [31:0]               req_wdata_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [31:0]               resp_rdata_o,
  output logic                      resp_err_o,
  output logic [NUM_REGIONS-1:0]    s_sel_o,
  output logic [31:0]               s_addr_o,
  output logic                      s_we_o,
  output logic [3:0]                s_wstrb_o,
  output logic [31:0]               s_wdata_o,
  input  logic [32*NUM_REGIONS-1:0] s_rdata_i,
  input  logic [NUM_REGIONS-1:0]    s_ack_i
);

  if (NUM_REGIONS < 1 || NUM_REGIONS > MAX_REGIONS || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mem_bus_ctrl: NUM_REGIONS must be 1..16 and TIMEOUT_CYCLES >= 1");
  end

  state_e                 state_q;
  logic [NUM_REGIONS-1:0] s_sel_q;
  logic [31:0]            s_addr_q;
  logic                   s_we_q;
  logic [3:0]             s_wstrb_q;
  logic [31:0]            s_wdata_q;
  logic [1:0]             size_q;
  logic [1:0]             off_q;
  logic                   resp_valid_q;
  logic                   resp_err_q;
  logic [31:0]            resp_rdata_q;

  logic [3:0]             req_idx;
  logic                   dec_err;
  logic [NUM_REGIONS-1:0] dec_sel;
  logic [31:0]            sel_rdata;
  logic                   ack_hit;
  logic                   tmo_hit;
  logic [3:0]             al_wstrb;
  logic [31:0]            al_wdata;
  logic [31:0]            al_rdata;

  assign req_idx = req_addr_i[REGION_SHIFT +: 4];

  always_comb begin
    dec_sel = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      dec_sel[i] = (req_idx == 4'(i));
    end
    dec_err = (32'(req_idx) >= NUM_REGIONS)
           || (req_size_i == SZ_ILLEGAL)
           || (req_we_i && READ_ONLY_MASK[req_idx])
           || (ALIGN_MASK[req_idx] && misaligned(req_size_i, req_addr_i[1:0]));
  end

  // Only the selected region's ack and data count; everything else is ignored.
  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (s_sel_q[i]) sel_rdata |= s_rdata_i[32*i +: 32];
    end
  end

  assign ack_hit = |(s_ack_i & s_sel_q);

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] tmo_cnt_d, tmo_cnt_q;

  assign tmo_cnt_d = (state_q == StAccess) ? tmo_cnt_q + 1'b1 : '0;
  assign tmo_hit   = (state_q == StAccess) && (tmo_cnt_d == CntW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  mem_lane_align u_lane_align (
    .wr_size_i (req_size_i),
    .wr_off_i  (req_addr_i[1:0]),
    .we_i      (req_we_i),
    .wdata_i   (req_wdata_i),
    .rd_size_i (size_q),
    .rd_off_i  (off_q),
    .rdata_i   (sel_rdata),
    .wstrb_o   (al_wstrb),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      s_sel_q      <= '0;
      s_addr_q     <= '0;
      s_we_q       <= 1'b0;
      s_wstrb_q    <= '0;
      s_wdata_q    <= '0;
      size_q       <= '0;
      off_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            if (dec_err) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q   <= StAccess;
              s_sel_q   <= dec_sel;
              s_addr_q  <= {req_addr_i[31:2], 2'b00};
              s_we_q    <= req_we_i;
              s_wstrb_q <= al_wstrb;
              s_wdata_q <= al_wdata;
              size_q    <= req_size_i;
              off_q     <= req_addr_i[1:0];
            end
          end
        end
        StAccess: begin
          // A completing ack on the terminal timeout cycle takes priority.
          if (ack_hit) begin
            state_q      <= StResp;
            s_sel_q      <= '0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= s_we_q ? 32'h0 : al_rdata;
          end else if (tmo_hit) begin
            state_q      <= StResp;
            s_sel_q      <= '0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end
        end
        StResp: begin
          if (resp_ready_i) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign s_sel_o      = s_sel_q;
  assign s_addr_o     = s_addr_q;
  assign s_we_o       = s_we_q;
  assign s_wstrb_o    = s_wstrb_q;
  assign s_wdata_o    = s_wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: random and directed requests, reference model,
// slave model and response monitor. Define BUS_TIMEOUT_EN to also cover the timeout path.
module tb_mem_bus_ctrl;

  localparam int          NREG  = 3;
  localparam logic [15:0] RO    = 16'h0001;
  localparam logic [15:0] AL    = 16'h0004;
  localparam int          TMO   = 4;
  localparam int          NEVER = 1000;
`ifdef BUS_TIMEOUT_EN
  localparam int          MAXD  = TMO + 1;
`else
  localparam int          MAXD  = 3;
`endif

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] word;
    int          delay;
    int          region;
  } slv_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } rsp_t;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 req_valid_i = 1'b0;
  logic                 req_ready_o;
  logic [31:0]          req_addr_i = '0;
  logic                 req_we_i = 1'b0;
  logic [1:0]           req_size_i = '0;
  logic [31:0]          req_wdata_i = '0;
  logic                 resp_valid_o;
  logic                 resp_ready_i = 1'b0;
  logic [31:0]          resp_rdata_o;
  logic                 resp_err_o;
  logic [NREG-1:0]      s_sel_o;
  logic [31:0]          s_addr_o;
  logic                 s_we_o;
  logic [3:0]           s_wstrb_o;
  logic [31:0]          s_wdata_o;
  logic [32*NREG-1:0]   s_rdata_i = '0;
  logic [NREG-1:0]      s_ack_i = '0;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   stall    = 0;
  logic tb_rst   = 1'b1;
  slv_t sq[$];
  rsp_t rq[$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  mem_bus_ctrl #(
    .NUM_REGIONS   (NREG),
    .READ_ONLY_MASK(RO),
    .ALIGN_MASK    (AL),
    .TIMEOUT_CYCLES(TMO)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_size_i  (req_size_i),
    .req_wdata_i (req_wdata_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o),
    .resp_err_o  (resp_err_o),
    .s_sel_o     (s_sel_o),
    .s_addr_o    (s_addr_o),
    .s_we_o      (s_we_o),
    .s_wstrb_o   (s_wstrb_o),
    .s_wdata_o   (s_wdata_o),
    .s_rdata_i   (s_rdata_i),
    .s_ack_i     (s_ack_i)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: decode, lane rules and read extraction from the bus rules, byte by byte.
  function automatic void model(input logic [31:0] addr, input logic we, input logic [1:0] size,
                                input logic [31:0] wdata, input logic [31:0] word,
                                input int delay, output logic err, output slv_t s,
                                output rsp_t r);
    int region, off, nb;
    logic [15:0] ro_m, al_m;
    ro_m   = RO;
    al_m   = AL;
    region = int'(addr[31:28]);
    off    = int'(addr[1:0]);
    nb     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err    = (region >= NREG) || (size == 2'd3) || (we && ro_m[region])
          || (al_m[region] && (off % nb) != 0);
    s.sel    = '0;
    if (region < NREG) s.sel[region] = 1'b1;
    s.addr   = {addr[31:2], 2'b00};
    s.we     = we;
    s.word   = word;
    s.delay  = delay;
    s.region = region;
    s.strb   = '0;
    if (we) begin
      if (nb == 4) s.strb = 4'hF;
      else for (int k = 0; k < nb; k++) if (off + k < 4) s.strb[off+k] = 1'b1;
    end
    case (nb)
      1:       s.wdata = {4{wdata[7:0]}};
      2:       s.wdata = {2{wdata[15:0]}};
      default: s.wdata = wdata;
    endcase
    r.rdata = '0;
    r.err   = err;
    r.lat   = err ? 1 : 2 + delay;
    r.acc   = 0;
    if (!err && !we) begin
      for (int k = 0; k < nb; k++) if (off + k < 4) r.rdata[8*k +: 8] = word[8*(off+k) +: 8];
    end
`ifdef BUS_TIMEOUT_EN
    if (!err && delay >= TMO) begin
      r.err   = 1'b1;
      r.rdata = '0;
      r.lat   = TMO + 1;
    end
`endif
  endfunction

  task automatic issue(input logic [31:0] addr, input logic we, input logic [1:0] size,
                       input logic [31:0] wdata, input logic [31:0] word, input int delay);
    logic err;
    slv_t s;
    rsp_t r;
    int   g = 0;
    model(addr, we, size, wdata, word, delay, err, s, r);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_we_i    = we;
    req_size_i  = size;
    req_wdata_i = wdata;
    while (!req_ready_o && g < 300) begin
      @(negedge clk_i);
      g++;
    end
    chk("req_accept", 32'(req_ready_o), 32'd1);
    if (req_ready_o) begin
      r.acc = cyc;
      if (!err) sq.push_back(s);
      rq.push_back(r);
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
  endtask

  task automatic rand_req();
    logic [31:0] addr;
    int          r;
    logic [1:0]  size;
    addr = $urandom;
    r    = $urandom_range(0, 9);
    addr[31:28] = (r < 3) ? 4'd0 : (r < 6) ? 4'd1 : (r < 9) ? 4'd2 : 4'($urandom_range(3, 15));
    size = ($urandom_range(0, 7) == 7) ? 2'd3 : 2'($urandom_range(0, 2));
    issue(addr, 1'($urandom_range(0, 1)), size, $urandom, $urandom, $urandom_range(0, MAXD));
    repeat ($urandom_range(0, 2)) @(negedge clk_i);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((rq.size() != 0 || resp_valid_o) && g < 300) begin
      @(negedge clk_i);
      g++;
    end
    chk("drain_pending", 32'(rq.size()), 32'd0);
  endtask

  // Slave model: checks the slave-side transaction every selected cycle, acks after its delay.
  initial begin
    slv_t cur;
    logic active = 1'b0;
    int   cnt    = 0;
    forever begin
      @(negedge clk_i);
      s_rdata_i = {$urandom, $urandom, $urandom};
      if (tb_rst) begin
        active  = 1'b0;
        s_ack_i = '0;
      end else if (s_sel_o != '0) begin
        if (!active) begin
          chk("sel_expected", 32'(sq.size()), 32'd1);
          if (sq.size() != 0) begin
            cur    = sq.pop_front();
            active = 1'b1;
            cnt    = 0;
          end
        end
        if (active) begin
          chk("s_sel", 32'(s_sel_o), 32'(cur.sel));
          chk("s_addr", s_addr_o, cur.addr);
          chk("s_we", 32'(s_we_o), 32'(cur.we));
          chk("s_wstrb", 32'(s_wstrb_o), 32'(cur.strb));
          if (cur.we) chk("s_wdata", s_wdata_o, cur.wdata);
          chk("req_ready_busy", 32'(req_ready_o), 32'd0);
          s_rdata_i[32*cur.region +: 32] = cur.word;
          s_ack_i = 3'($urandom) & ~cur.sel;
          if (cnt == cur.delay) s_ack_i = s_ack_i | cur.sel;
          cnt++;
        end else begin
          s_ack_i = '0;
        end
      end else begin
        active  = 1'b0;
        s_ack_i = 3'($urandom);
      end
    end
  end

  // Response monitor with random backpressure.
  initial begin
    rsp_t mcur;
    logic in_resp    = 1'b0;
    logic hs_pending = 1'b0;
    forever begin
      @(negedge clk_i);
      if (tb_rst) begin
        in_resp      = 1'b0;
        hs_pending   = 1'b0;
        resp_ready_i = 1'b0;
      end else begin
        if (hs_pending) begin
          chk("valid_after_hs", 32'(resp_valid_o), 32'd0);
          chk("ready_after_hs", 32'(req_ready_o), 32'd1);
          in_resp    = 1'b0;
          hs_pending = 1'b0;
        end
        if (resp_valid_o) begin
          if (!in_resp) begin
            chk("resp_expected", 32'(rq.size() != 0), 32'd1);
            if (rq.size() != 0) mcur = rq.pop_front();
            in_resp = 1'b1;
            chk("resp_latency", 32'(cyc - mcur.acc), 32'(mcur.lat));
          end
          chk("resp_rdata", resp_rdata_o, mcur.rdata);
          chk("resp_err", 32'(resp_err_o), 32'(mcur.err));
          chk("req_ready_resp", 32'(req_ready_o), 32'd0);
          if (stall > 0) begin
            resp_ready_i = 1'b0;
            stall--;
          end else begin
            resp_ready_i = 1'($urandom_range(0, 1));
          end
          hs_pending = resp_ready_i;
        end else begin
          if (in_resp) chk("valid_held", 32'(resp_valid_o), 32'd1);
          in_resp      = 1'b0;
          resp_ready_i = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    tb_rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_resp_err", 32'(resp_err_o), 32'd0);
    chk("rst_resp_rdata", resp_rdata_o, 32'd0);
    chk("rst_s_sel", 32'(s_sel_o), 32'd0);
    chk("rst_s_we", 32'(s_we_o), 32'd0);
    chk("rst_s_wstrb", 32'(s_wstrb_o), 32'd0);
    chk("rst_s_addr", s_addr_o, 32'd0);
    chk("rst_s_wdata", s_wdata_o, 32'd0);

    issue(32'h1000_0004, 1'b0, 2'd2, 32'h0, 32'hDEAD_BEEF, 0);
    issue(32'h1000_0003, 1'b1, 2'd0, 32'h0000_00A5, 32'h0, 1);
    issue(32'h1000_0002, 1'b0, 2'd1, 32'h0, 32'h1234_5678, 0);
    issue(32'h1000_0003, 1'b1, 2'd1, 32'h0000_BEEF, 32'h0, 0);
    issue(32'h1000_0001, 1'b0, 2'd2, 32'h0, 32'hA1B2_C3D4, 2);
    issue(32'h0000_0000, 1'b1, 2'd2, 32'h1111_1111, 32'h0, 0);
    issue(32'h2000_0002, 1'b0, 2'd2, 32'h0, 32'h0, 0);
    issue(32'h3000_0000, 1'b0, 2'd2, 32'h0, 32'h0, 0);
    issue(32'h1000_0000, 1'b0, 2'd3, 32'h0, 32'h0, 0);
    issue(32'h0000_0008, 1'b0, 2'd0, 32'h0, 32'h55AA_7F01, 0);
    wait_idle();
    stall = 5;
    issue(32'h2000_0004, 1'b0, 2'd2, 32'h0, 32'h0BAD_F00D, 1);
    wait_idle();

    for (int i = 0; i < 200; i++) rand_req();
    wait_idle();

    issue(32'h1000_0008, 1'b0, 2'd2, 32'h0, 32'hCAFE_F00D, NEVER);
    chk("rst_mid_sel_before", 32'(s_sel_o), 32'h2);
    @(negedge clk_i);
    tb_rst = 1'b1;
    rst_i  = 1'b1;
    @(negedge clk_i);
    chk("rst_mid_sel", 32'(s_sel_o), 32'd0);
    chk("rst_mid_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_mid_ready", 32'(req_ready_o), 32'd1);
    rst_i = 1'b0;
    sq.delete();
    rq.delete();
    @(negedge clk_i);
    tb_rst = 1'b0;

`ifdef BUS_TIMEOUT_EN
    issue(32'h1000_0000, 1'b0, 2'd2, 32'h0, 32'h1357_9BDF, NEVER);
    issue(32'h2000_0000, 1'b1, 2'd2, 32'h2468_ACE0, 32'h0, TMO - 1);
    issue(32'h1000_0004, 1'b0, 2'd2, 32'h0, 32'h7777_8888, TMO);
    wait_idle();
`endif

    for (int i = 0; i < 20; i++) rand_req();
    wait_idle();
    @(negedge clk_i);
    chk("end_req_ready", 32'(req_ready_o), 32'd1);
    chk("end_s_sel", 32'(s_sel_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
